// File: rtl/reset_sequencer.sv
// Releases per-subsystem resets in order once the PLL lock has been stable long enough,
// then raises ready; any loss of lock re-asserts every reset and restarts the sequence.
module reset_sequencer #(
  parameter int STABLE_CYCLES = 1024,
  parameter int NUM_STAGES    = 3,
  parameter int STAGE_GAP     = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  lock_in,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  ready,
  output logic [1:0]            state_dbg
);

  localparam int MAX_CNT = (STABLE_CYCLES > STAGE_GAP) ? STABLE_CYCLES : STAGE_GAP;
  localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam int SW      = $clog2(NUM_STAGES + 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [SW-1:0]         stage_q, stage_d;
  logic [NUM_STAGES-1:0] rst_q, rst_d;
  logic                  ready_q, ready_d;
  logic                  sync1, lock_s;

  // lock_in is asynchronous to clock; two flops before anything looks at it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= lock_in;
      lock_s <= sync1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      stage_q <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    // Loss of lock outranks any terminal count reached on the same cycle.
    if (state_q != WAIT_LOCK && !lock_s) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
      stage_d = '0;
      rst_d   = '1;
      ready_d = 1'b0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          rst_d   = '1;
          ready_d = 1'b0;
          cnt_d   = '0;
          stage_d = '0;
          if (lock_s) state_d = STABILIZE;
        end
        STABILIZE: begin
          if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
            rst_d[0] = 1'b0;
            cnt_d    = '0;
            stage_d  = SW'(1);
            state_d  = RELEASE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RELEASE: begin
          if (cnt_q == CW'(STAGE_GAP - 1)) begin
            if (stage_q < SW'(NUM_STAGES)) begin
              for (int i = 0; i < NUM_STAGES; i++) begin
                if (SW'(i) == stage_q) rst_d[i] = 1'b0;
              end
              stage_d = stage_q + 1'b1;
              cnt_d   = '0;
            end else begin
              ready_d = 1'b1;
              state_d = RUN;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RUN: begin
          rst_d   = '0;
          ready_d = 1'b1;
        end
        default: state_d = WAIT_LOCK;
      endcase
    end
  end

  assign rst_out   = rst_q;
  assign ready     = ready_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a nominal instance (8/4/3) and a corner instance (1/1/1)
// share clock, reset and lock; expectations come from edge-count formulas and a lock-run model.
module tb_reset_sequencer;
  localparam int S = 8, G = 4, N = 3;
  localparam int CS = 1, CG = 1, CN = 1;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic lock_in = 1'b0;
  logic [N-1:0]  rst_out;
  logic          ready;
  logic [1:0]    state_dbg;
  logic [CN-1:0] rst_c;
  logic          ready_c;
  logic [1:0]    state_c;
  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  reset_sequencer #(.STABLE_CYCLES(S), .NUM_STAGES(N), .STAGE_GAP(G)) dut (
    .clock(clock), .reset_n(reset_n), .lock_in(lock_in),
    .rst_out(rst_out), .ready(ready), .state_dbg(state_dbg));

  reset_sequencer #(.STABLE_CYCLES(CS), .NUM_STAGES(CN), .STAGE_GAP(CG)) dut_c (
    .clock(clock), .reset_n(reset_n), .lock_in(lock_in),
    .rst_out(rst_c), .ready(ready_c), .state_dbg(state_c));

  // Reference: t = number of consecutive edges at which synchronized lock was already high.
  // Stage k is released once t reaches 1+S+k*G, ready once t reaches 1+S+N*G.
  int   t;
  logic m1, m2;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      t  <= 0;
      m1 <= 1'b0;
      m2 <= 1'b0;
    end else begin
      t  <= m2 ? ((t < 100000) ? t + 1 : t) : 0;
      m2 <= m1;
      m1 <= lock_in;
    end
  end

  logic [N-1:0]  m_rst;
  logic          m_ready;
  logic [CN-1:0] mc_rst;
  logic          mc_ready;
  always_comb begin
    m_rst  = '1;
    mc_rst = '1;
    for (int k = 0; k < N; k++)  m_rst[k]  = (t < 1 + S + k * G);
    for (int k = 0; k < CN; k++) mc_rst[k] = (t < 1 + CS + k * CG);
    m_ready  = (t >= 1 + S + N * G);
    mc_ready = (t >= 1 + CS + CN * CG);
  end

  // Expected {ready, rst_out} after edge x, counting from lock_in rising before edge 0.
  function automatic logic [3:0] nom(int x);
    if (x < 0) return 4'b0111;
    return {x >= 2 + S + N * G, x < 2 + S + 2 * G, x < 2 + S + G, x < 2 + S};
  endfunction

  task automatic do_reset();
    lock_in = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    lock_in = 1'b1;
    #1;
    checks++;
    if ({ready, rst_out, state_dbg} !== {1'b0, 3'b111, 2'd0}) begin
      failures++;
      $display("FAIL reset_main ready=%b rst_out=%b state=%0d expected 0 111 0", ready, rst_out, state_dbg);
    end
    checks++;
    if ({ready_c, rst_c} !== 2'b01) begin
      failures++;
      $display("FAIL reset_corner ready=%b rst_out=%b expected 0 1", ready_c, rst_c);
    end
    repeat (4) begin
      @(negedge clock);
      checks++;
      if ({ready, rst_out, ready_c, rst_c} !== 6'b011101) begin
        failures++;
        $display("FAIL reset_hold ready=%b rst_out=%b corner=%b%b expected 0 111 01", ready, rst_out, ready_c, rst_c);
      end
    end
    lock_in = 1'b0;
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clock);
      checks++;
      if ({ready, rst_out, ready_c, rst_c} !== 6'b011101) begin
        failures++;
        $display("FAIL reset_nolock ready=%b rst_out=%b corner=%b%b expected 0 111 01", ready, rst_out, ready_c, rst_c);
      end
    end
  endtask

  task automatic test_nominal();
    logic [3:0] ex;
    logic [1:0] exc;
    do_reset();
    for (int e = 0; e <= 30; e++) begin
      lock_in = 1'b1;
      @(negedge clock);
      ex  = nom(e);
      exc = {e >= 4, e < 3};
      checks++;
      if ({ready, rst_out} !== ex) begin
        failures++;
        $display("FAIL nominal edge=%0d got=%b expected=%b", e, {ready, rst_out}, ex);
      end
      checks++;
      if ({ready_c, rst_c} !== exc) begin
        failures++;
        $display("FAIL corner edge=%0d got=%b expected=%b", e, {ready_c, rst_c}, exc);
      end
    end
  endtask

  task automatic test_glitch();
    logic [3:0] ex;
    do_reset();
    for (int e = 0; e <= 34; e++) begin
      lock_in = !(e >= 6 && e <= 8);
      @(negedge clock);
      ex = (e <= 9) ? 4'b0111 : nom(e - 9);
      checks++;
      if ({ready, rst_out} !== ex) begin
        failures++;
        $display("FAIL glitch edge=%0d got=%b expected=%b", e, {ready, rst_out}, ex);
      end
      checks++;
      if ({ready_c, rst_c} !== {mc_ready, mc_rst}) begin
        failures++;
        $display("FAIL glitch_corner edge=%0d got=%b expected=%b", e, {ready_c, rst_c}, {mc_ready, mc_rst});
      end
    end
  endtask

  task automatic test_loss_release();
    logic [3:0] ex;
    do_reset();
    for (int e = 0; e <= 48; e++) begin
      lock_in = !(e >= 15 && e < 25);
      @(negedge clock);
      ex = (e <= 16) ? nom(e) : nom(e - 25);
      checks++;
      if ({ready, rst_out} !== ex) begin
        failures++;
        $display("FAIL loss_release edge=%0d got=%b expected=%b", e, {ready, rst_out}, ex);
      end
    end
  endtask

  task automatic test_loss_run();
    logic [3:0] ex;
    do_reset();
    for (int e = 0; e <= 64; e++) begin
      lock_in = !(e >= 30 && e < 40);
      @(negedge clock);
      ex = (e <= 31) ? nom(e) : nom(e - 40);
      checks++;
      if ({ready, rst_out} !== ex) begin
        failures++;
        $display("FAIL loss_run edge=%0d got=%b expected=%b", e, {ready, rst_out}, ex);
      end
      checks++;
      if ({ready_c, rst_c} !== {mc_ready, mc_rst}) begin
        failures++;
        $display("FAIL loss_run_corner edge=%0d got=%b expected=%b", e, {ready_c, rst_c}, {mc_ready, mc_rst});
      end
    end
  endtask

  task automatic test_collision();
    logic [3:0] ex;
    do_reset();
    for (int e = 0; e <= 32; e++) begin
      lock_in = (e != 8);
      @(negedge clock);
      ex = (e <= 9) ? nom(e) : nom(e - 9);
      checks++;
      if ({ready, rst_out} !== ex) begin
        failures++;
        $display("FAIL collide_stab edge=%0d got=%b expected=%b", e, {ready, rst_out}, ex);
      end
    end
    do_reset();
    for (int e = 0; e <= 36; e++) begin
      lock_in = (e != 12);
      @(negedge clock);
      ex = (e <= 13) ? nom(e) : nom(e - 13);
      checks++;
      if ({ready, rst_out} !== ex) begin
        failures++;
        $display("FAIL collide_rel edge=%0d got=%b expected=%b", e, {ready, rst_out}, ex);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] ex;
    do_reset();
    lock_in = 1'b1;
    repeat (13) @(negedge clock);
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if ({ready, rst_out, ready_c, rst_c} !== 6'b011101) begin
      failures++;
      $display("FAIL async_reset ready=%b rst_out=%b corner=%b%b expected 0 111 01", ready, rst_out, ready_c, rst_c);
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int e = 0; e <= 24; e++) begin
      @(negedge clock);
      ex = nom(e);
      checks++;
      if ({ready, rst_out} !== ex) begin
        failures++;
        $display("FAIL async_restart edge=%0d got=%b expected=%b", e, {ready, rst_out}, ex);
      end
    end
  endtask

  task automatic test_random();
    int hold = 0;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      if (hold == 0) begin
        lock_in = ~lock_in;
        hold = lock_in ? $urandom_range(1, 40) : $urandom_range(1, 5);
      end
      hold--;
      if ($urandom_range(0, 199) == 0) begin
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
      end
      @(negedge clock);
      checks++;
      if ({ready, rst_out} !== {m_ready, m_rst}) begin
        failures++;
        $display("FAIL random_main cycle=%0d got=%b expected=%b", c, {ready, rst_out}, {m_ready, m_rst});
      end
      checks++;
      if ({ready_c, rst_c} !== {mc_ready, mc_rst}) begin
        failures++;
        $display("FAIL random_corner cycle=%0d got=%b expected=%b", c, {ready_c, rst_c}, {mc_ready, mc_rst});
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_glitch();
    test_loss_release();
    test_loss_run();
    test_collision();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Reset sequencer that sits directly downstream of the PLL wrapper. It consumes the PLL lock indication (`lock_in`) in the PLL output clock domain. It waits until lock has been continuously stable for a programmable time, then releases a set of active-high reset outputs one after another, and finally raises `ready`. Any loss of lock immediately re-asserts every reset and restarts the sequence. The outputs drive the design's per-subsystem resets: memory controller first, then video, then CPU.

## Interface
- `STABLE_CYCLES`, default 1024: consecutive cycles that the synchronized lock must stay high before the first reset is released; must be ≥1.
- `NUM_STAGES`, default 3: number of reset outputs; must be ≥1.
- `STAGE_GAP`, default 16: cycles between successive stage releases, and between the last release and `ready`; must be ≥1.

- `clock` in 1: PLL output clock; the only clock.
- `reset_n` in 1: one clock; reset is asynchronous and active-low.
- `lock_in` in 1: PLL lock, asynchronous to `clock`; feeds the synchronizer.
- `rst_out` out NUM_STAGES: active-high resets; bit 0 is released first.
- `ready` out 1: high once all stages are released and the final gap has elapsed.

## Operation
- `lock_in` passes through a 2-flop synchronizer; its output is `lock_s`. Both flops reset to 0.
- Counters:
  - `cnt` is sized by $clog2 of max(STABLE_CYCLES, STAGE_GAP).
  - `stage` is sized by $clog2(NUM_STAGES+1).
- FSM states:
  - WAIT_LOCK:
    - `rst_out` all 1, `ready`=0.
    - If `lock_s`=1, go to STABILIZE with `cnt`=0.
  - STABILIZE:
    - If `lock_s`=0, go to WAIT_LOCK.
    - Else if `cnt`==STABLE_CYCLES-1, clear `rst_out[0]`, set `cnt`=0 and `stage`=1, go to RELEASE.
    - Else increment `cnt`.
  - RELEASE:
    - If `lock_s`=0, go to WAIT_LOCK.
    - Else if `cnt`==STAGE_GAP-1 and `stage`<NUM_STAGES, clear `rst_out[stage]`, increment `stage`, set `cnt`=0.
    - Else if `cnt`==STAGE_GAP-1 and `stage`==NUM_STAGES, set `ready`=1 and go to RUN.
    - Else increment `cnt`.
  - RUN:
    - Outputs hold: `rst_out` all 0, `ready`=1.
    - If `lock_s`=0, go to WAIT_LOCK.
- Entering WAIT_LOCK from any state sets every `rst_out` bit to 1, `ready` to 0, `cnt` to 0 and `stage` to 0, all on the same edge.
- Released bits never re-assert individually. The only re-assertion is all bits together on loss of lock.
- With NUM_STAGES=1, `rst_out[0]` is released at the end of STABILIZE and `ready` follows STAGE_GAP cycles later.

## Timing
- Asynchronous reset (`reset_n`=0), taking effect immediately and independent of `clock`:
  - state WAIT_LOCK, `rst_out` all 1, `ready` 0, `cnt` 0, `stage` 0, synchronizer flops 0.
- After deassertion of `reset_n`, the first state change occurs no earlier than the edge after `lock_s` rises.
- `lock_s` lags `lock_in` by 2 edges. A `lock_in` pulse shorter than one clock may be missed; this is acceptable.
- Reference edges, counting from `lock_in` going high before edge 0:
  - `lock_s`=1 after edge 1, state STABILIZE after edge 2.
  - `rst_out[0]` falls after edge 2+STABLE_CYCLES.
  - `rst_out[k]` falls after edge 2+STABLE_CYCLES+k·STAGE_GAP.
  - `ready` rises after edge 2+STABLE_CYCLES+NUM_STAGES·STAGE_GAP.
- Loss of lock:
  - `lock_in` falling before edge n makes `lock_s`=0 after edge n+1.
  - All `rst_out` go to 1 and `ready` to 0 after edge n+2.
- If `lock_s` drops on the same cycle as a terminal count (STABILIZE or RELEASE), loss of lock wins: WAIT_LOCK, no release.
- All outputs are registered; no combinational path from `lock_in` to any output.

## Test plan
- Nominal, with STABLE_CYCLES=8, STAGE_GAP=4, NUM_STAGES=3, `lock_in` high before edge 0 -> `rst_out[0]`, `rst_out[1]` and `rst_out[2]` fall after edges 10, 14 and 18; `ready` rises after edge 22; outputs then hold.
- Glitch during STABILIZE: `lock_in` low for 3 cycles starting at edge 6 -> return to WAIT_LOCK, `rst_out`=3'b111 throughout; after `lock_in` recovers, the full 8-cycle stabilization restarts from `cnt`=0.
- Loss mid-RELEASE: `lock_in` falls before edge 15 (`rst_out`=3'b100 at that point) -> `rst_out`=3'b111 after edge 17; `ready` never rose; the sequence restarts when lock returns.
- Loss in RUN: `lock_in` falls before edge 30 -> `rst_out`=3'b111 and `ready`=0 after edge 32; relocking reproduces the nominal timing offsets.
- Async reset: pull `reset_n` low mid-RELEASE, between clock edges -> `rst_out` all 1 and `ready` 0 immediately, without waiting for an edge; after release with `lock_in` still high, `rst_out[0]` falls 2+STABLE_CYCLES edges later.
- Corner parameters NUM_STAGES=1, STAGE_GAP=1, STABLE_CYCLES=1 -> `rst_out[0]` falls after edge 3, `ready` rises after edge 4.
